// File: rtl/hc4e_run_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hc4e_run_ctrl_if
//  Purpose  : Request/status bundle between the debug panel, the HC4e core
//             and the run-control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface hc4e_run_ctrl_if #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
);
    // Requests and core observation fed into the sequencer
    logic                  run_req;
    logic                  halt_req;
    logic                  step_req;
    logic                  fast_mode;
    logic                  bp_enable;
    logic [PC_WIDTH-1:0]   bp_addr;
    logic [PC_WIDTH-1:0]   pc_in;

    // Clock and status produced by the sequencer
    logic                  cpu_clk;
    logic [1:0]            state;
    logic                  halted;
    logic                  bp_hit;
    logic                  step_done;
    logic [CNT_WIDTH-1:0]  cycle_count;

    // Panel / core side: issues requests, observes status
    modport master (
        output run_req, halt_req, step_req, fast_mode, bp_enable, bp_addr, pc_in,
        input  cpu_clk, state, halted, bp_hit, step_done, cycle_count
    );

    // Sequencer side
    modport slave (
        input  run_req, halt_req, step_req, fast_mode, bp_enable, bp_addr, pc_in,
        output cpu_clk, state, halted, bp_hit, step_done, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/hc4e_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hc4e_run_ctrl
//  Purpose  : Run-control sequencer for the HC4e core. Derives cpu_clk from
//             the board clock through a prescaler and provides run, halt,
//             single-step and PC-match breakpoint control.
//  Revision : 1.0 - initial release
// ============================================================================
module hc4e_run_ctrl #(
    parameter int PRESCALE_DIV = 10_000_000,
    parameter int PC_WIDTH     = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  wire logic          clock,
    input  wire logic          reset,
    hc4e_run_ctrl_if.slave     bus
);

    localparam int              c_PW      = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [c_PW-1:0] c_TERM    = c_PW'(PRESCALE_DIV - 1);

    localparam logic [1:0]      c_ST_HALT = 2'd0;
    localparam logic [1:0]      c_ST_RUN  = 2'd1;
    localparam logic [1:0]      c_ST_STEP = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [c_PW-1:0]      r_presc;
    logic                 r_cpu_clk;
    logic                 r_bp_hit;
    logic                 r_step_done;
    logic                 r_halt_pending;
    logic                 r_bp_skip;
    logic [CNT_WIDTH-1:0] r_cycle_count;

    logic                 w_cpu_clk_nxt;
    logic                 w_bp_hit_nxt;
    logic                 w_step_done_nxt;
    logic                 w_halt_pending_nxt;
    logic                 w_bp_skip_nxt;

    logic [PC_WIDTH-1:0]  w_pc;
    logic [PC_WIDTH-1:0]  w_bp_addr;
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_halt_now;
    logic                 w_bp_match;
    logic                 w_rise;

    assign w_pc      = bus.pc_in;
    assign w_bp_addr = bus.bp_addr;

    // A tick is the moment cpu_clk may change; never while halted, every
    // board clock in fast mode, otherwise on the prescaler terminal count.
    assign w_tick     = (r_state != c_ST_HALT) && (bus.fast_mode || (r_presc == c_TERM));

    // Cycle boundary in RUN: cpu_clk high and a tick is due.
    assign w_boundary = (r_state == c_ST_RUN) && w_tick && r_cpu_clk;
    assign w_halt_now = w_boundary && (r_halt_pending || bus.halt_req);
    assign w_bp_match = w_boundary && !w_halt_now && bus.bp_enable &&
                        !r_bp_skip && (w_pc == w_bp_addr);

    assign w_rise     = w_cpu_clk_nxt && !r_cpu_clk;

    // Prescaler: cleared while halted, in fast mode and on each tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if ((r_state == c_ST_HALT) || bus.fast_mode || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: halts only ever happen with cpu_clk high.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_HALT: begin
                if (bus.run_req) begin
                    w_state_nxt = c_ST_RUN;
                end else if (bus.step_req) begin
                    w_state_nxt = c_ST_STEP;
                end
            end
            c_ST_RUN: begin
                if (w_halt_now || w_bp_match) begin
                    w_state_nxt = c_ST_HALT;
                end
            end
            c_ST_STEP: begin
                if (w_tick && !r_cpu_clk) begin
                    w_state_nxt = c_ST_HALT;
                end
            end
            default: w_state_nxt = c_ST_HALT;
        endcase
    end

    // Output decode: next cpu_clk level, status pulses and sticky flags.
    always_comb begin
        w_cpu_clk_nxt      = r_cpu_clk;
        w_bp_hit_nxt       = 1'b0;
        w_step_done_nxt    = 1'b0;
        w_halt_pending_nxt = r_halt_pending;
        w_bp_skip_nxt      = r_bp_skip;
        case (r_state)
            c_ST_HALT: begin
                w_cpu_clk_nxt      = 1'b1;
                w_halt_pending_nxt = 1'b0;
                // Resuming from a breakpoint must execute the stopped PC once.
                if (bus.run_req) begin
                    w_bp_skip_nxt = 1'b1;
                end
            end
            c_ST_RUN: begin
                if (w_boundary) begin
                    if (w_halt_now) begin
                        w_halt_pending_nxt = 1'b0;
                    end else if (w_bp_match) begin
                        w_bp_hit_nxt = 1'b1;
                    end else begin
                        w_cpu_clk_nxt = 1'b0;
                        w_bp_skip_nxt = 1'b0;
                    end
                end else begin
                    // A halt arriving mid-cycle is remembered so the cycle
                    // is never cut short.
                    if (bus.halt_req) begin
                        w_halt_pending_nxt = 1'b1;
                    end
                    if (w_tick) begin
                        w_cpu_clk_nxt = 1'b1;
                    end
                end
            end
            c_ST_STEP: begin
                if (w_tick) begin
                    if (r_cpu_clk) begin
                        w_cpu_clk_nxt = 1'b0;
                    end else begin
                        w_cpu_clk_nxt   = 1'b1;
                        w_step_done_nxt = 1'b1;
                    end
                end
            end
            default: w_cpu_clk_nxt = 1'b1;
        endcase
    end

    // Registered outputs keep cpu_clk glitch-free; reset forces it high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cpu_clk      <= 1'b1;
            r_bp_hit       <= 1'b0;
            r_step_done    <= 1'b0;
            r_halt_pending <= 1'b0;
            r_bp_skip      <= 1'b0;
        end else begin
            r_cpu_clk      <= w_cpu_clk_nxt;
            r_bp_hit       <= w_bp_hit_nxt;
            r_step_done    <= w_step_done_nxt;
            r_halt_pending <= w_halt_pending_nxt;
            r_bp_skip      <= w_bp_skip_nxt;
        end
    end

    // Retired-cycle counter: one count per cpu_clk rising edge, wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (w_rise) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign bus.cpu_clk     = r_cpu_clk;
    assign bus.state       = r_state;
    assign bus.halted      = (r_state == c_ST_HALT) && r_cpu_clk;
    assign bus.bp_hit      = r_bp_hit;
    assign bus.step_done   = r_step_done;
    assign bus.cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_hc4e_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hc4e_run_ctrl
//  Purpose  : Self-checking bench for hc4e_run_ctrl (prescaler of 4, 4-bit
//             retired-cycle counter so the wrap is reachable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hc4e_run_ctrl;

    localparam int PDIV = 4;
    localparam int PCW  = 8;
    localparam int CW   = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    hc4e_run_ctrl_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus ();

    hc4e_run_ctrl #(
        .PRESCALE_DIV (PDIV),
        .PC_WIDTH     (PCW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int            n_pass  = 0;
    int            n_total = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    logic          prev_cpu = 1'b1;
    bit            pc_auto  = 1'b0;

    // Advance one board clock, sample 1ns later; every cpu_clk rise pops the
    // scoreboard and compares cycle_count. pc_in advances when the core commits.
    task automatic tick();
        logic [CW-1:0] e;
        @(posedge clock);
        #1;
        if (bus.cpu_clk === 1'b1 && prev_cpu === 1'b0) begin
            if (pc_auto) bus.pc_in = bus.pc_in + 1'b1;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_rise: unexpected cpu_clk rise, cycle_count=%0d, expected no rise", bus.cycle_count);
            end else begin
                e = exp_q.pop_front();
                if (bus.cycle_count !== e)
                    $display("FAIL sb_cycle_count: got %0d expected %0d", bus.cycle_count, e);
                else
                    n_pass++;
            end
        end
        prev_cpu = bus.cpu_clk;
    endtask

    task automatic expect_rises(input int n);
        repeat (n) begin
            exp_cnt = exp_cnt + 1'b1;
            exp_q.push_back(exp_cnt);
        end
    endtask

    task automatic wait_level(input logic lvl, input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.cpu_clk === lvl) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_halt(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.state === 2'd0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic pulse_run();
        bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
    endtask

    task automatic pulse_halt();
        bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    endtask

    task automatic pulse_step();
        bus.step_req = 1'b1; tick(); bus.step_req = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus.cpu_clk !== 1'b1) $display("FAIL rst_cpu_clk: got %b expected 1", bus.cpu_clk); else n_pass++;
        n_total++; if (bus.state !== 2'd0) $display("FAIL rst_state: got %0d expected 0", bus.state); else n_pass++;
        n_total++; if (bus.cycle_count !== 4'd0) $display("FAIL rst_count: got %0d expected 0", bus.cycle_count); else n_pass++;
        n_total++; if (bus.halted !== 1'b1) $display("FAIL rst_halted: got %b expected 1", bus.halted); else n_pass++;
        n_total++; if ({bus.bp_hit, bus.step_done} !== 2'b00) $display("FAIL rst_pulses: got %b expected 00", {bus.bp_hit, bus.step_done}); else n_pass++;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_run();
        int c;
        pulse_run();
        wait_level(1'b0, 20, c);
        n_total++; if (c !== PDIV) $display("FAIL run_first_fall: got %0d clocks expected %0d", c, PDIV); else n_pass++;
        expect_rises(3);
        repeat (24) tick();
        n_total++; if (bus.cycle_count !== 4'd3) $display("FAIL run_count_24: got %0d expected 3", bus.cycle_count); else n_pass++;
        n_total++; if (bus.cpu_clk !== 1'b0) $display("FAIL run_phase_24: got %b expected 0", bus.cpu_clk); else n_pass++;
        expect_rises(1);
        pulse_halt();
        wait_halt(30, c);
        n_total++; if (c !== 7) $display("FAIL run_halt_latency: got %0d expected 7", c); else n_pass++;
        repeat (12) tick();
        n_total++; if (bus.cpu_clk !== 1'b1 || bus.halted !== 1'b1) $display("FAIL run_halted_idle: got cpu_clk=%b halted=%b expected 1/1", bus.cpu_clk, bus.halted); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL run_drain: got %0d pending rises expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_step();
        int c;
        int extra;
        expect_rises(1);
        pulse_step();
        wait_level(1'b0, 20, c);
        n_total++; if (c !== PDIV) $display("FAIL step_fall: got %0d expected %0d", c, PDIV); else n_pass++;
        wait_level(1'b1, 20, c);
        n_total++; if (c !== PDIV) $display("FAIL step_low_len: got %0d expected %0d", c, PDIV); else n_pass++;
        n_total++; if (bus.step_done !== 1'b1) $display("FAIL step_done_pulse: got %b expected 1", bus.step_done); else n_pass++;
        n_total++; if (bus.state !== 2'd0 || bus.halted !== 1'b1) $display("FAIL step_return: got state=%0d halted=%b expected 0/1", bus.state, bus.halted); else n_pass++;
        extra = 0;
        repeat (10) begin tick(); if (bus.step_done === 1'b1) extra++; end
        n_total++; if (extra != 0) $display("FAIL step_done_once: got %0d extra pulses expected 0", extra); else n_pass++;
        n_total++; if (bus.cycle_count !== exp_cnt) $display("FAIL step_count: got %0d expected %0d", bus.cycle_count, exp_cnt); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL step_drain: got %0d expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_halt_midcycle();
        int c;
        int falls;
        pulse_run();
        wait_level(1'b0, 20, c);
        expect_rises(1);
        pulse_halt();
        wait_level(1'b1, 20, c);
        n_total++; if (c + 1 !== PDIV) $display("FAIL mid_low_len: got %0d expected %0d", c + 1, PDIV); else n_pass++;
        wait_halt(20, c);
        n_total++; if (c !== PDIV) $display("FAIL mid_halt_at_boundary: got %0d expected %0d", c, PDIV); else n_pass++;
        n_total++; if (bus.cpu_clk !== 1'b1) $display("FAIL mid_cpu_high: got %b expected 1", bus.cpu_clk); else n_pass++;
        falls = 0;
        repeat (16) begin tick(); if (bus.cpu_clk === 1'b0) falls++; end
        n_total++; if (falls != 0) $display("FAIL mid_no_falls: got %0d low samples expected 0", falls); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL mid_drain: got %0d expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_breakpoint();
        int c;
        int hits;
        bus.pc_in = 8'h00; bus.bp_addr = 8'h05; bus.bp_enable = 1'b1; pc_auto = 1'b1;
        expect_rises(5);
        pulse_run();
        hits = 0; c = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.bp_hit === 1'b1) hits++;
            if (bus.state === 2'd0) begin c = i; break; end
        end
        n_total++; if (c < 0) $display("FAIL bp_stop: got no halt expected halt"); else n_pass++;
        n_total++; if (bus.pc_in !== 8'h05 || bus.cpu_clk !== 1'b1) $display("FAIL bp_stop_pc: got pc=%h cpu_clk=%b expected 05/1", bus.pc_in, bus.cpu_clk); else n_pass++;
        repeat (5) begin tick(); if (bus.bp_hit === 1'b1) hits++; end
        n_total++; if (hits != 1) $display("FAIL bp_hit_once: got %0d pulses expected 1", hits); else n_pass++;
        // Resume: the instruction at the breakpoint runs without re-hitting.
        expect_rises(2);
        pulse_run();
        wait_level(1'b0, 20, c);
        n_total++; if (c !== PDIV) $display("FAIL bp_resume_fall: got %0d expected %0d", c, PDIV); else n_pass++;
        wait_level(1'b1, 20, c);
        wait_level(1'b0, 20, c);
        pulse_halt();
        hits = 0; c = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.bp_hit === 1'b1) hits++;
            if (bus.state === 2'd0) begin c = i; break; end
        end
        n_total++; if (hits != 0 || c < 0) $display("FAIL bp_no_rehit: got hits=%0d halt_wait=%0d expected 0 hits and halt", hits, c); else n_pass++;
        n_total++; if (bus.pc_in !== 8'h07) $display("FAIL bp_resume_pc: got %h expected 07", bus.pc_in); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d expected 0", exp_q.size()); else n_pass++;
        pc_auto = 1'b0; bus.bp_enable = 1'b0;
    endtask

    task automatic test_fast();
        int c;
        bus.fast_mode = 1'b1;
        expect_rises(2);
        pulse_run();
        wait_level(1'b0, 10, c);
        n_total++; if (c !== 1) $display("FAIL fast_fall: got %0d expected 1", c); else n_pass++;
        wait_level(1'b1, 10, c);
        n_total++; if (c !== 1) $display("FAIL fast_rise: got %0d expected 1", c); else n_pass++;
        wait_level(1'b0, 10, c);
        bus.run_req = 1'b1; bus.halt_req = 1'b1;
        tick();
        bus.run_req = 1'b0; bus.halt_req = 1'b0;
        wait_halt(10, c);
        n_total++; if (c !== 1 || bus.cpu_clk !== 1'b1) $display("FAIL fast_run_halt: got wait=%0d cpu_clk=%b expected 1/1", c, bus.cpu_clk); else n_pass++;
        repeat (6) tick();
        n_total++; if (exp_q.size() != 0) $display("FAIL fast_drain: got %0d expected 0", exp_q.size()); else n_pass++;
        bus.fast_mode = 1'b0;
    endtask

    task automatic test_reset_midcycle_and_wrap();
        int c;
        int r;
        logic p;
        pulse_run();
        wait_level(1'b0, 20, c);
        tick();
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus.cpu_clk !== 1'b1 || bus.state !== 2'd0) $display("FAIL arst_mid: got cpu_clk=%b state=%0d expected 1/0", bus.cpu_clk, bus.state); else n_pass++;
        n_total++; if (bus.cycle_count !== 4'd0) $display("FAIL arst_count: got %0d expected 0", bus.cycle_count); else n_pass++;
        prev_cpu = 1'b1;
        exp_cnt  = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        // Sixteen retired cycles wrap the 4-bit counter through 15 back to 0.
        bus.fast_mode = 1'b1;
        expect_rises(16);
        pulse_run();
        r = 0;
        for (int i = 0; i < 100 && r < 16; i++) begin
            p = prev_cpu;
            tick();
            if (bus.cpu_clk === 1'b1 && p === 1'b0) r++;
        end
        pulse_halt();
        n_total++; if (bus.state !== 2'd0) $display("FAIL wrap_halt: got state %0d expected 0", bus.state); else n_pass++;
        n_total++; if (bus.cycle_count !== 4'd0) $display("FAIL wrap_count: got %0d expected 0", bus.cycle_count); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL wrap_drain: got %0d expected 0", exp_q.size()); else n_pass++;
        bus.fast_mode = 1'b0;
    endtask

    initial begin
        bus.run_req   = 1'b0;
        bus.halt_req  = 1'b0;
        bus.step_req  = 1'b0;
        bus.fast_mode = 1'b0;
        bus.bp_enable = 1'b0;
        bus.bp_addr   = '0;
        bus.pc_in     = '0;
        test_reset();
        test_run();
        test_step();
        test_halt_midcycle();
        test_breakpoint();
        test_fast();
        test_reset_midcycle_and_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hc4e_run_ctrl.md
Name: hc4e_run_ctrl

Overview:
Run-control sequencer for the HC4e core. It generates the core's processor clock `cpu_clk` from the board `clock` with a programmable prescaler, and supports run, halt, single-step and PC-match breakpoint modes. It sits between the board clock/reset and the core, replacing the free-running prescaler. It exposes status and a retired-cycle counter for the debug panel.

Parameters:
PRESCALE_DIV, 10_000_000, board clocks per cpu_clk half-period in normal mode (>=1)
PC_WIDTH, 8, width of the program counter and breakpoint address
CNT_WIDTH, 16, width of the retired-cycle counter

Ports:
clock  input  1  board clock; all logic is on its rising edge
reset  input  1  asynchronous, active-high reset
run_req  input  1  one-clock pulse: start free-running
halt_req  input  1  one-clock pulse: stop at the next cycle boundary
step_req  input  1  one-clock pulse: execute exactly one CPU cycle (only honoured in HALT)
fast_mode  input  1  1 = half-period of one board clock (prescaler bypassed)
bp_enable  input  1  enables the breakpoint compare
bp_addr  input  PC_WIDTH  breakpoint program counter value
pc_in  input  PC_WIDTH  current core PC (the core's pc_out)
cpu_clk  output  1  processor clock to the core; idles high
state  output  2  0=HALT, 1=RUN, 2=STEP (3 unused)
halted  output  1  1 when state==HALT and cpu_clk==1
bp_hit  output  1  one-clock pulse when a breakpoint stops the core
step_done  output  1  one-clock pulse when a STEP cycle completes
cycle_count  output  CNT_WIDTH  number of completed cpu_clk rising edges

Behaviour:
- Reset (async, while reset=1): state=HALT, cpu_clk=1, prescaler=0, cycle_count=0, bp_hit=0, step_done=0, halt_pending=0, bp_skip=0.
- CPU cycle: cpu_clk falls (low phase; the core's RAM strobes are active), then rises (core commits). cpu_clk is registered and glitch-free. A cycle is never truncated: a low phase always lasts a full half-period.
- Tick: in normal mode, the prescaler counts 0..PRESCALE_DIV-1 and ticks on the terminal count, then wraps to 0. With fast_mode=1, every board clock is a tick. In HALT the prescaler is held at 0. A fast_mode change takes effect at the next tick decision, and the prescaler is cleared.
- Each tick toggles cpu_clk while in RUN or STEP.
- HALT: cpu_clk held at 1.
  - run_req -> RUN, with bp_skip set.
  - step_req -> STEP.
  - If both arrive in the same clock, run_req wins.
- RUN, at a tick with cpu_clk=1 (cycle boundary), checked in this order:
  - If halt_pending is set or halt_req=1: go to HALT and clear halt_pending. cpu_clk stays 1.
  - Else, if bp_enable=1, bp_skip=0 and pc_in==bp_addr: go to HALT and pulse bp_hit for one clock.
  - Otherwise drive cpu_clk to 0 and clear bp_skip.
- RUN, on halt_req while cpu_clk=0: set halt_pending. The cycle completes (the rise happens), and the halt is taken at the next boundary tick. run_req in RUN is ignored.
- STEP: the first tick drives cpu_clk to 0 and the next tick drives it to 1. On that rising edge, return to HALT and pulse step_done. STEP ignores breakpoints. halt_req during STEP is ignored.
- cycle_count increments on every 0->1 transition of cpu_clk and wraps from all-ones to 0.
- halt_req has priority over run_req in RUN; step_req is ignored outside HALT.
- Reset mid-cycle forces cpu_clk=1 immediately.

Test Plan:
1. PRESCALE_DIV=4, reset, run_req -> cpu_clk toggles every 4 clocks (period 8); cycle_count reaches 3 after 24 clocks from the first fall.
2. In HALT, step_req -> exactly one low phase of 4 clocks, then a rise; step_done pulses once; state returns to 0; cycle_count increments by 1.
3. RUN with halt_req pulsed 1 clock after cpu_clk falls -> the low phase still lasts 4 clocks, the rise occurs, then HALT with cpu_clk=1 and no further falls.
4. bp_enable=1, bp_addr=0x05, pc_in advancing per cycle from 0x00 -> stops with pc_in=0x05 and cpu_clk=1; bp_hit pulses once. A following run_req executes a cycle at 0x05 without re-hitting.
5. fast_mode=1, run -> cpu_clk toggles every board clock; run_req and halt_req in the same clock while in RUN -> halt taken.
6. reset asserted while cpu_clk=0 in RUN -> cpu_clk=1, state=HALT, cycle_count=0 asynchronously. cycle_count wraps 0xFFFF->0x0000 (force near-wrap with CNT_WIDTH=4: 15->0).
